// File: rtl/pkg_ft601_ctrl_defines.sv
// Shared FT601 controller definitions: bus widths, word/byte-enable types and lane-mask helper.
package pkg_ft601_ctrl_defines;

  localparam int unsigned WIDTH_DATA  = 32;
  localparam int unsigned CNT_CHANNLS = 4;

  typedef logic [WIDTH_DATA-1:0]  ft_word_t;
  typedef logic [CNT_CHANNLS-1:0] ft_be_t;

  // Expand byte enables to a full-word bit mask (bit i of be covers byte i).
  function automatic ft_word_t be2mask(input ft_be_t be);
    ft_word_t m;
    m = '0;
    for (int unsigned i = 0; i < CNT_CHANNLS; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/ft601_mem_ring_ctrl_if.sv
// Upstream (s_*) and downstream (m_*) valid/ready streams of the ring controller.
interface ft601_mem_ring_ctrl_if;
  import pkg_ft601_ctrl_defines::*;

  logic     s_valid;
  logic     s_ready;
  ft_word_t s_data;
  ft_be_t   s_be;
  logic     m_valid;
  logic     m_ready;
  ft_word_t m_data;

  modport slave  (input  s_valid, s_data, s_be, m_ready,
                  output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, s_be, m_ready,
                  input  s_ready, m_valid, m_data);
endinterface

// File: rtl/ft601_skid2.sv
// Two-entry valid/ready output buffer; push and pop may coincide.
module ft601_skid2
  import pkg_ft601_ctrl_defines::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       push,
  input  ft_word_t   push_data,
  input  logic       pop,
  output logic [1:0] cnt,
  output ft_word_t   head
);

  ft_word_t tail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= push_data;
          else             tail <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; head advances and the new word lands behind it.
          if (cnt == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_xKx32_mdl.sv
// Single-port byte-lane RAM, registered read data (read-first), 1-cycle latency.
module mem_xKx32_mdl
  import pkg_ft601_ctrl_defines::*;
#(
  parameter int unsigned T_MSZ = 12
) (
  input  logic             clk,
  input  logic             ce,
  input  ft_be_t           wen,
  input  logic [T_MSZ-1:0] addr,
  input  ft_word_t         din,
  output ft_word_t         qout
);

  localparam int unsigned DEPTH = 1 << T_MSZ;

  ft_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      for (int unsigned i = 0; i < CNT_CHANNLS; i++) begin
        if (wen[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
      end
      qout <= mem[addr];
    end
  end

endmodule

// File: rtl/ft601_mem_ring_ctrl.sv
// Ring-buffer FIFO over a single-port RAM: write/read arbitration, pointers, level and output skid.
module ft601_mem_ring_ctrl
  import pkg_ft601_ctrl_defines::*;
#(
  parameter int unsigned T_MSZ = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  ft601_mem_ring_ctrl_if.slave bus,
  output logic                 mem_ce,
  output ft_be_t               mem_wen,
  output ft_word_t             mem_din,
  output logic [T_MSZ-1:0]     mem_addr,
  input  ft_word_t             mem_qout,
  output logic [T_MSZ:0]       level,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned DEPTH = 1 << T_MSZ;

  logic             rdy_en;
  logic             rd_turn;
  logic             rd_inflight;
  logic [T_MSZ-1:0] wr_ptr;
  logic [T_MSZ-1:0] rd_ptr;
  logic [1:0]       skid_cnt;
  logic             s_ready_pre;
  logic             rd_want;
  logic             wr_req;
  logic             wr_gnt;
  logic             wr_mem;
  logic             rd_gnt;
  logic             skid_pop;

  assign full  = (level == (T_MSZ+1)'(DEPTH));
  assign empty = (level == '0);

  // Read only when the skid can absorb every word already on its way.
  assign rd_want     = ~empty & ~flush & (({1'b0, skid_cnt} + 3'(rd_inflight)) < 3'd2);
  assign s_ready_pre = rdy_en & ~full & ~flush;
  assign bus.s_ready = s_ready_pre & ~(rd_want & rd_turn);

  assign wr_req = bus.s_valid & s_ready_pre;
  assign wr_gnt = bus.s_valid & bus.s_ready;
  assign wr_mem = wr_gnt & (|bus.s_be);
  assign rd_gnt = rd_want & ~wr_gnt;

  // RAM port: a write stores the lane-cleaned word across all lanes.
  always_comb begin
    mem_ce   = 1'b0;
    mem_wen  = '0;
    mem_addr = rd_ptr;
    mem_din  = bus.s_data & be2mask(bus.s_be);
    if (wr_mem) begin
      mem_ce   = 1'b1;
      mem_wen  = '1;
      mem_addr = wr_ptr;
    end else if (rd_gnt) begin
      mem_ce = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_en      <= 1'b0;
      rd_turn     <= 1'b0;
      rd_inflight <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        rd_turn     <= 1'b0;
        rd_inflight <= 1'b0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        level       <= '0;
      end else begin
        rd_inflight <= rd_gnt;
        if (wr_mem) wr_ptr <= wr_ptr + T_MSZ'(1);
        if (rd_gnt) rd_ptr <= rd_ptr + T_MSZ'(1);
        if (wr_mem)      level <= level + (T_MSZ+1)'(1);
        else if (rd_gnt) level <= level - (T_MSZ+1)'(1);
        if (wr_req & rd_want) rd_turn <= ~rd_turn;
      end
    end
  end

  assign skid_pop    = bus.m_valid & bus.m_ready;
  assign bus.m_valid = (skid_cnt != 2'd0);

  ft601_skid2 u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (flush),
    .push      (rd_inflight & ~flush),
    .push_data (mem_qout),
    .pop       (skid_pop),
    .cnt       (skid_cnt),
    .head      (bus.m_data)
  );

endmodule
